// File: rtl/ping_pong_counter_param.sv
// rtl/ping_pong_counter_param.sv - bounded up/down counter with ping-pong and wrap modes
module ping_pong_counter_param #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_MIN = 0,
    parameter int DEFAULT_MAX = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             flip,
    input  logic             load,
    input  logic [WIDTH-1:0] min_in,
    input  logic [WIDTH-1:0] max_in,
    output logic             direction,
    output logic [WIDTH-1:0] out,
    output logic             turn,
    output logic             bounds_err
);

    localparam logic [WIDTH-1:0] RST_MIN = WIDTH'(DEFAULT_MIN);
    localparam logic [WIDTH-1:0] RST_MAX = WIDTH'(DEFAULT_MAX);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] min_r;
    logic [WIDTH-1:0] max_r;

    // Bounds are only ever accepted with min < max, so +/-1 at a bound stays in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r      <= RST_MIN;
            max_r      <= RST_MAX;
            out        <= RST_MIN;
            direction  <= 1'b1;
            turn       <= 1'b0;
            bounds_err <= 1'b0;
        end else if (load) begin
            turn <= 1'b0;
            if (min_in < max_in) begin
                min_r      <= min_in;
                max_r      <= max_in;
                out        <= min_in;
                direction  <= 1'b1;
                bounds_err <= 1'b0;
            end else begin
                bounds_err <= 1'b1;
            end
        end else if (!enable) begin
            turn <= 1'b0;
        end else if (flip) begin
            direction <= ~direction;
            turn      <= 1'b1;
        end else if (!mode) begin
            if (direction) begin
                if (out == max_r) begin
                    direction <= 1'b0;
                    out       <= max_r - ONE;
                    turn      <= 1'b1;
                end else begin
                    out  <= out + ONE;
                    turn <= 1'b0;
                end
            end else begin
                if (out == min_r) begin
                    direction <= 1'b1;
                    out       <= min_r + ONE;
                    turn      <= 1'b1;
                end else begin
                    out  <= out - ONE;
                    turn <= 1'b0;
                end
            end
        end else begin
            if (direction) begin
                if (out == max_r) begin
                    out  <= min_r;
                    turn <= 1'b1;
                end else begin
                    out  <= out + ONE;
                    turn <= 1'b0;
                end
            end else begin
                if (out == min_r) begin
                    out  <= max_r;
                    turn <= 1'b1;
                end else begin
                    out  <= out - ONE;
                    turn <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ping_pong_counter_param.sv
// tb/tb_ping_pong_counter_param.sv - bench for ping_pong_counter_param
module tb_ping_pong_counter_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, mode, flip, load;
    logic [3:0] min_in, max_in;
    logic       direction, turn, bounds_err;
    logic [3:0] out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ping_pong_counter_param #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .flip(flip),
        .load(load), .min_in(min_in), .max_in(max_in), .direction(direction),
        .out(out), .turn(turn), .bounds_err(bounds_err)
    );

    typedef struct {
        logic       en, md, fl, ld;
        logic [3:0] mi, ma;
        logic [3:0] x_out;
        logic       x_dir, x_turn, x_err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic en, logic md, logic fl, logic ld, logic [3:0] mi,
                                logic [3:0] ma, logic [3:0] xo, logic xd, logic xt, logic xe);
        vec_t v;
        v.en = en; v.md = md; v.fl = fl; v.ld = ld; v.mi = mi; v.ma = ma;
        v.x_out = xo; v.x_dir = xd; v.x_turn = xt; v.x_err = xe;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic md, input logic fl, input logic ld,
                         input logic [3:0] mi, input logic [3:0] ma);
        @(negedge clk);
        enable = en; mode = md; flip = fl; load = ld; min_in = mi; max_in = ma;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 0; mode = 0; flip = 0; load = 0; min_in = 0; max_in = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: position within [lo,hi], moving one step; overshoot is reflected
    // in ping-pong mode and folded modulo the span in wrap mode.
    int m_lo, m_hi, m_cnt, m_up, m_err, m_turn;

    task automatic model_reset();
        m_lo = 0; m_hi = 15; m_cnt = 0; m_up = 1; m_err = 0; m_turn = 0;
    endtask

    task automatic model_step(input int en, input int md, input int fl, input int ld,
                              input int mi, input int ma);
        int nxt, span;
        if (ld != 0) begin
            m_turn = 0;
            if (mi < ma) begin
                m_lo = mi; m_hi = ma; m_cnt = mi; m_up = 1; m_err = 0;
            end else begin
                m_err = 1;
            end
        end else if (en == 0) begin
            m_turn = 0;
        end else if (fl != 0) begin
            m_up = 1 - m_up;
            m_turn = 1;
        end else begin
            nxt = m_cnt + ((m_up != 0) ? 1 : -1);
            m_turn = 0;
            if (md == 0) begin
                if (nxt > m_hi) begin
                    nxt = 2 * m_hi - nxt; m_up = 0; m_turn = 1;
                end else if (nxt < m_lo) begin
                    nxt = 2 * m_lo - nxt; m_up = 1; m_turn = 1;
                end
            end else begin
                span = m_hi - m_lo + 1;
                if (nxt > m_hi || nxt < m_lo) m_turn = 1;
                nxt = m_lo + ((nxt - m_lo + span) % span);
            end
            m_cnt = nxt;
        end
    endtask

    initial begin
        logic en_r, md_r, fl_r, ld_r;
        logic [3:0] mi_r, ma_r;

        rst_n = 1'b0;
        enable = 0; mode = 0; flip = 0; load = 0; min_in = 0; max_in = 0;
        #12;
        chk("reset out", out, 0);
        chk("reset dir", direction, 1);
        chk("reset turn", turn, 0);
        chk("reset err", bounds_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-run ping-pong over default bounds
        for (int k = 1; k <= 15; k++) add(1, 0, 0, 0, 0, 0, 4'(k), 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 14, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 13, 0, 0, 0);
        // Bounded ping-pong 3..6, load while disabled
        add(0, 0, 0, 1, 3, 6, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 4, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 5, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 4, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 4, 1, 1, 0);
        // Illegal load, then enable hold at out=5 (flip ignored while disabled)
        add(1, 0, 0, 1, 9, 9, 4, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 5, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 5, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 5, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 6, 1, 0, 1);
        // Valid load together with flip: load wins
        add(1, 0, 1, 1, 0, 2, 0, 1, 0, 0);
        // Wrap 2..5 with flip
        add(0, 1, 0, 1, 2, 5, 2, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        add(1, 1, 0, 0, 0, 0, 2, 1, 1, 0);
        add(1, 1, 0, 0, 0, 0, 3, 1, 0, 0);
        add(1, 1, 1, 0, 0, 0, 3, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 5, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        // Mode change mid-run keeps out and direction
        add(1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 3, 1, 1, 0);
        add(1, 0, 0, 1, 5, 2, 3, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].md, tbl[i].fl, tbl[i].ld, tbl[i].mi, tbl[i].ma);
            chk($sformatf("vec%0d out", i), out, tbl[i].x_out);
            chk($sformatf("vec%0d dir", i), direction, tbl[i].x_dir);
            chk($sformatf("vec%0d turn", i), turn, tbl[i].x_turn);
            chk($sformatf("vec%0d err", i), bounds_err, tbl[i].x_err);
        end

        // Asynchronous reset between edges at out=7, with bounds_err set beforehand
        do_reset();
        for (int k = 0; k < 7; k++) drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 5, 5);
        chk("pre-reset out", out, 7);
        chk("pre-reset err", bounds_err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out", out, 0);
        chk("async dir", direction, 1);
        chk("async err", bounds_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        chk("first count", out, 1);

        // Randomized run against the reference model
        do_reset();
        model_reset();
        md_r = 0;
        for (int c = 0; c < 3000; c++) begin
            en_r = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) md_r = ~md_r;
            fl_r = ($urandom_range(0, 7) == 0);
            ld_r = ($urandom_range(0, 15) == 0);
            mi_r = 4'($urandom_range(0, 15));
            ma_r = 4'($urandom_range(0, 15));
            drive(en_r, md_r, fl_r, ld_r, mi_r, ma_r);
            model_step(int'(en_r), int'(md_r), int'(fl_r), int'(ld_r), int'(mi_r), int'(ma_r));
            if (out !== 4'(m_cnt) || direction !== 1'(m_up) || turn !== 1'(m_turn) ||
                bounds_err !== 1'(m_err)) begin
                chk($sformatf("rand%0d out", c), out, m_cnt);
                chk($sformatf("rand%0d dir", c), direction, m_up);
                chk($sformatf("rand%0d turn", c), turn, m_turn);
                chk($sformatf("rand%0d err", c), bounds_err, m_err);
            end else begin
                tests++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
